// File: rtl/vexriscv_mem_arbiter.sv
// Shares one single-port 64-bit SRAM between the VexRiscv instruction and data ports.
// Data has priority; the instruction port is forced through after MaxInstrStall consecutive losses.
module vexriscv_mem_arbiter #(
    parameter int MemLatency    = 1,
    parameter int MaxInstrStall = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    input  logic [31:0] instr_addr_i,
    input  logic [63:0] instr_wdata_i,
    input  logic [7:0]  instr_strb_i,
    input  logic        instr_we_i,
    output logic        instr_rvalid_o,
    output logic [63:0] instr_rdata_o,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic [63:0] data_wdata_i,
    input  logic [7:0]  data_strb_i,
    input  logic        data_we_i,
    output logic        data_rvalid_o,
    output logic [63:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    output logic [7:0]  mem_strb_o,
    output logic        mem_we_o,
    input  logic [63:0] mem_rdata_i,
    output logic [31:0] conflict_cnt_o
);
    // A zero-width counter is illegal, so MaxInstrStall = 0 keeps one bit pinned at 0.
    localparam int StallW = (MaxInstrStall > 0) ? $clog2(MaxInstrStall + 1) : 1;
    localparam logic [StallW-1:0] StallMax = StallW'(MaxInstrStall);

    logic [StallW-1:0]     stall_cnt;
    logic                  instr_win;
    logic                  data_win;
    logic [MemLatency-1:0] tag_valid;
    logic [MemLatency-1:0] tag_port;

    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (!rst_i) begin
            if (instr_req_i && data_req_i) begin
                if (stall_cnt == StallMax) begin
                    instr_win = 1'b1;
                end else begin
                    data_win = 1'b1;
                end
            end else begin
                instr_win = instr_req_i;
                data_win  = data_req_i;
            end
        end
    end

    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_win;
    assign mem_req_o   = instr_win | data_win;

    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        mem_we_o    = 1'b0;
        if (data_win) begin
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
            mem_strb_o  = data_strb_i;
            mem_we_o    = data_we_i;
        end else if (instr_win) begin
            mem_addr_o  = instr_addr_i;
            mem_wdata_o = instr_wdata_i;
            mem_strb_o  = instr_strb_i;
            mem_we_o    = instr_we_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (!instr_req_i || instr_win) begin
            stall_cnt <= '0;
        end else if (stall_cnt != StallMax) begin
            stall_cnt <= stall_cnt + StallW'(1);
        end
    end

    // Each stage holds {valid, port}; port 1 means the data port owns the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_valid <= '0;
            tag_port  <= '0;
        end else begin
            tag_valid[0] <= mem_req_o;
            tag_port[0]  <= data_win;
            for (int i = 1; i < MemLatency; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_port[i]  <= tag_port[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else if (instr_req_i && data_req_i && (conflict_cnt_o != 32'hFFFF_FFFF)) begin
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
        end
    end

    assign instr_rvalid_o = tag_valid[MemLatency-1] & ~tag_port[MemLatency-1];
    assign data_rvalid_o  = tag_valid[MemLatency-1] &  tag_port[MemLatency-1];
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 64'd0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : 64'd0;

endmodule

// File: tb/tb_vexriscv_mem_arbiter.sv
// Bench for vexriscv_mem_arbiter: one instance with (latency 1, stall 4), one with (latency 3, stall 0).
// Grant vectors come from tables; responses are tracked per instance in a due-cycle scoreboard.
module tb_vexriscv_mem_arbiter;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;
    localparam logic [31:0] IADDR  = 32'h0000_1000;
    localparam logic [31:0] DADDR  = 32'h8000_0010;
    localparam logic [63:0] IWDATA = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DWDATA = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [7:0]  ISTRB  = 8'hFF;
    localparam logic [7:0]  DSTRB  = 8'h0F;

    typedef struct packed {
        logic ireq;
        logic dreq;
        logic iwe;
        logic dwe;
        logic exp_ig;
        logic exp_dg;
    } vec_t;

    typedef struct {
        int   due;
        logic port;
    } sb_t;

    logic        clk;
    logic        rst;
    logic        run;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          exp_conf [2];
    sb_t         q0 [$];
    sb_t         q1 [$];

    logic        ireq [2];
    logic        dreq [2];
    logic        iwe [2];
    logic        dwe [2];
    logic        ig [2];
    logic        dg [2];
    logic        iv [2];
    logic        dv [2];
    logic [63:0] ir [2];
    logic [63:0] dr [2];
    logic        mreq [2];
    logic [31:0] maddr [2];
    logic [63:0] mwdata [2];
    logic [7:0]  mstrb [2];
    logic        mwe [2];
    logic [31:0] conf [2];
    logic [63:0] mem_rdata;

    function automatic logic [63:0] pat(input int c);
        return {32'hDEAD_BEEF ^ 32'(c), 32'hCAFE_F00D + 32'(c)};
    endfunction

    assign mem_rdata = pat(cyc);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    vexriscv_mem_arbiter #(.MemLatency(LAT0), .MaxInstrStall(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq[0]), .instr_gnt_o(ig[0]), .instr_addr_i(IADDR),
        .instr_wdata_i(IWDATA), .instr_strb_i(ISTRB), .instr_we_i(iwe[0]),
        .instr_rvalid_o(iv[0]), .instr_rdata_o(ir[0]),
        .data_req_i(dreq[0]), .data_gnt_o(dg[0]), .data_addr_i(DADDR),
        .data_wdata_i(DWDATA), .data_strb_i(DSTRB), .data_we_i(dwe[0]),
        .data_rvalid_o(dv[0]), .data_rdata_o(dr[0]),
        .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]), .mem_wdata_o(mwdata[0]),
        .mem_strb_o(mstrb[0]), .mem_we_o(mwe[0]), .mem_rdata_i(mem_rdata),
        .conflict_cnt_o(conf[0])
    );

    vexriscv_mem_arbiter #(.MemLatency(LAT1), .MaxInstrStall(0)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(ireq[1]), .instr_gnt_o(ig[1]), .instr_addr_i(IADDR),
        .instr_wdata_i(IWDATA), .instr_strb_i(ISTRB), .instr_we_i(iwe[1]),
        .instr_rvalid_o(iv[1]), .instr_rdata_o(ir[1]),
        .data_req_i(dreq[1]), .data_gnt_o(dg[1]), .data_addr_i(DADDR),
        .data_wdata_i(DWDATA), .data_strb_i(DSTRB), .data_we_i(dwe[1]),
        .data_rvalid_o(dv[1]), .data_rdata_o(dr[1]),
        .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]), .mem_wdata_o(mwdata[1]),
        .mem_strb_o(mstrb[1]), .mem_we_o(mwe[1]), .mem_rdata_i(mem_rdata),
        .conflict_cnt_o(conf[1])
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic drive_port(input int d, input vec_t v);
        ireq[d] = v.ireq;
        dreq[d] = v.dreq;
        iwe[d]  = v.iwe;
        dwe[d]  = v.dwe;
    endtask

    task automatic check_output(input int d, input vec_t v);
        sb_t e;
        string p;
        p = $sformatf("dut%0d", d);
        check({p, " instr_gnt"}, 64'(ig[d]), 64'(v.exp_ig));
        check({p, " data_gnt"}, 64'(dg[d]), 64'(v.exp_dg));
        check({p, " mem_req"}, 64'(mreq[d]), 64'(v.exp_ig | v.exp_dg));
        check({p, " mem_addr"}, 64'(maddr[d]), v.exp_dg ? 64'(DADDR) : v.exp_ig ? 64'(IADDR) : 64'd0);
        check({p, " mem_wdata"}, mwdata[d], v.exp_dg ? DWDATA : v.exp_ig ? IWDATA : 64'd0);
        check({p, " mem_strb"}, 64'(mstrb[d]), v.exp_dg ? 64'(DSTRB) : v.exp_ig ? 64'(ISTRB) : 64'd0);
        check({p, " mem_we"}, 64'(mwe[d]), v.exp_dg ? 64'(v.dwe) : v.exp_ig ? 64'(v.iwe) : 64'd0);
        check({p, " conflict_cnt"}, 64'(conf[d]), 64'(exp_conf[d]));
        if (v.exp_ig || v.exp_dg) begin
            e.port = v.exp_dg;
            e.due  = cyc + ((d == 0) ? LAT0 : LAT1);
            if (d == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        if (v.ireq && v.dreq) exp_conf[d]++;
    endtask

    task automatic apply_stimulus(input vec_t v0, input vec_t v1);
        @(posedge clk);
        #1;
        drive_port(0, v0);
        drive_port(1, v1);
        @(negedge clk);
        check_output(0, v0);
        check_output(1, v1);
    endtask

    task automatic check_resp(input int d, input logic e_iv, input logic e_dv);
        string p;
        p = $sformatf("dut%0d", d);
        check({p, " instr_rvalid"}, 64'(iv[d]), 64'(e_iv));
        check({p, " data_rvalid"}, 64'(dv[d]), 64'(e_dv));
        check({p, " instr_rdata"}, ir[d], e_iv ? pat(cyc) : 64'd0);
        check({p, " data_rdata"}, dr[d], e_dv ? pat(cyc) : 64'd0);
    endtask

    // Response scoreboard: every grant must produce exactly one response on its due cycle.
    always @(negedge clk) begin
        logic e_iv0, e_dv0, e_iv1, e_dv1;
        if (run) begin
            e_iv0 = 1'b0; e_dv0 = 1'b0; e_iv1 = 1'b0; e_dv1 = 1'b0;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                e_dv0 = q0[0].port;
                e_iv0 = !q0[0].port;
                q0.delete(0);
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e_dv1 = q1[0].port;
                e_iv1 = !q1[0].port;
                q1.delete(0);
            end
            check_resp(0, e_iv0, e_dv0);
            check_resp(1, e_iv1, e_dv1);
        end
    end

    vec_t z;
    vec_t tab0 [14];
    vec_t tab1 [6];

    initial begin
        z = '0;
        // {ireq, dreq, iwe, dwe, exp_ig, exp_dg}
        tab0 = '{
            '{0,1,0,0,0,1}, '{1,0,0,0,1,0}, '{0,1,0,1,0,1},
            '{1,1,0,0,0,1}, '{1,1,0,0,0,1}, '{1,1,0,0,0,1}, '{1,1,0,0,0,1},
            '{1,1,0,0,1,0}, '{1,1,0,1,0,1}, '{1,0,0,0,1,0}, '{0,0,0,0,0,0},
            '{1,1,0,0,0,1}, '{1,0,1,0,1,0}, '{0,0,0,0,0,0}
        };
        tab1 = '{
            '{1,1,0,0,1,0}, '{1,1,0,0,1,0}, '{0,1,0,0,0,1},
            '{1,0,0,0,1,0}, '{0,1,0,1,0,1}, '{1,0,0,0,1,0}
        };
        run = 1'b0;
        rst = 1'b1;
        exp_conf[0] = 0;
        exp_conf[1] = 0;
        drive_port(0, z);
        drive_port(1, z);
        @(posedge clk);
        run = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) apply_stimulus(z, z);
        for (int i = 0; i < 14; i++) apply_stimulus(tab0[i], z);
        for (int i = 0; i < 6; i++) apply_stimulus(z, tab1[i]);
        for (int i = 0; i < 4; i++) apply_stimulus(z, z);

        // Build up instruction stall on dut0 and put a data read in flight on dut1, then reset.
        apply_stimulus('{1,1,0,0,0,1}, z);
        apply_stimulus('{1,1,0,0,0,1}, z);
        apply_stimulus('{1,1,0,0,0,1}, '{0,1,0,0,0,1});
        @(posedge clk);
        #1 rst = 1'b1;
        q0.delete();
        q1.delete();
        exp_conf[0] = 0;
        exp_conf[1] = 0;
        ireq[0] = 1'b1;
        dreq[0] = 1'b1;
        dreq[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst instr_gnt", 64'(ig[0]), 64'd0);
            check("rst data_gnt", 64'(dg[0]), 64'd0);
            check("rst mem_req", 64'(mreq[0]), 64'd0);
            check("rst mem_addr", 64'(maddr[0]), 64'd0);
            check("rst mem_wdata", mwdata[0], 64'd0);
            check("rst dut1 data_gnt", 64'(dg[1]), 64'd0);
            check("rst conflict_cnt", 64'(conf[0]), 64'd0);
            @(posedge clk);
        end
        #1;
        drive_port(0, z);
        drive_port(1, z);
        rst = 1'b0;

        // After release the stall counter must start from zero: four data wins, then instruction.
        for (int i = 0; i < 4; i++) apply_stimulus('{1,1,0,0,0,1}, z);
        apply_stimulus('{1,1,0,0,1,0}, z);
        for (int i = 0; i < 5; i++) apply_stimulus(z, z);

        check("dut0 scoreboard drained", 64'(q0.size()), 64'd0);
        check("dut1 scoreboard drained", 64'(q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vexriscv_mem_arbiter.md
Name: vexriscv_mem_arbiter

Overview:
- Shares one 64-bit single-port SRAM between the VexRiscv instruction and data memory ports, for unified-memory SoC builds.
- Arbitrates each cycle with data priority and a bounded instruction-starvation guard.
- Drives the winner onto the SRAM and routes read data back to the correct requester after a fixed memory latency, tracked by a tag pipeline.
- Exports a saturating conflict counter for fuzzing coverage.

Parameters:
- MemLatency, 1, cycles from an accepted mem_req_o to valid mem_rdata_i (>=1).
- MaxInstrStall, 4, consecutive conflict losses the instruction port tolerates before it is forced to win (0 = instruction always wins a conflict).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset
- instr_req_i  in  1  instruction request
- instr_gnt_o  out  1  instruction request accepted this cycle
- instr_addr_i  in  32  byte address
- instr_wdata_i  in  64  write data
- instr_strb_i  in  8  byte strobes
- instr_we_i  in  1  write enable
- instr_rvalid_o  out  1  response for an accepted instruction request
- instr_rdata_o  out  64  read data
- data_req_i / data_gnt_o / data_addr_i / data_wdata_i / data_strb_i / data_we_i / data_rvalid_o / data_rdata_o: same widths and meanings, for the data port
- mem_req_o  out  1  SRAM request
- mem_addr_o  out  32  SRAM byte address (winner's, passed unchanged)
- mem_wdata_o  out  64  SRAM write data
- mem_strb_o  out  8  SRAM strobes
- mem_we_o  out  1  SRAM write enable
- mem_rdata_i  in  64  SRAM read data
- conflict_cnt_o  out  32  saturating count of cycles where both ports requested

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - starvation counter, tag pipeline and conflict_cnt_o are 0.
  - While rst_i is high, all gnt, rvalid and mem_req_o outputs are 0 and all data/address outputs are 0.
- Grant is combinational in the request cycle; there are no wait states beyond arbitration loss.
  - Only one port requests: that port wins.
  - Both request: data wins, unless stall_cnt == MaxInstrStall, in which case instruction wins.
  - Neither requests: mem_req_o = 0; mem_addr_o, mem_wdata_o, mem_strb_o and mem_we_o are all 0.
- A port's gnt_o is 1 only in the cycle it wins. The loser must hold its request stable until granted.
- stall_cnt (width clog2(MaxInstrStall+1)):
  - +1 when instr_req_i && !instr_gnt_o, saturating at MaxInstrStall.
  - Cleared when instr_gnt_o = 1 or instr_req_i = 0.
- Winner mux: mem_addr_o, mem_wdata_o, mem_strb_o and mem_we_o carry the winner's inputs unchanged in the grant cycle.
- Tag pipeline: MemLatency stages of {valid, port}.
  - Stage 0 loads {mem_req_o, winner} each cycle.
  - The last stage drives response routing: its port's rvalid_o = 1 exactly MemLatency cycles after the grant. This applies to reads and writes; a write response is an acknowledge.
  - The addressed port's rdata_o = mem_rdata_i when its rvalid_o = 1, else 0. The other port's rdata_o = 0.
  - Back-to-back grants, including alternating ports, are fully pipelined: one response per cycle, in grant order.
- conflict_cnt_o: +1 on every cycle with instr_req_i && data_req_i (outside reset); saturates at 0xFFFFFFFF.
- Reset mid-operation: in-flight tags are discarded, so no rvalid is issued for them after reset release. stall_cnt and conflict_cnt_o clear immediately (asynchronously).
- The arbiter performs no address relocation or range checks; the SRAM's address mapping applies.

Test Plan:
- Reset then release, no requests -> mem_req_o = 0 and all gnt/rvalid = 0 for 10 cycles; conflict_cnt_o = 0.
- Data only: read at 0x80000010 at cycle t, mem_rdata_i = 0xDEADBEEF_CAFEF00D at t+1 (MemLatency = 1) -> data_gnt_o = 1 at t; data_rvalid_o = 1 and data_rdata_o = 0xDEADBEEF_CAFEF00D at t+1; instr_rvalid_o = 0.
- Both ports requesting continuously, MaxInstrStall = 4 -> grant pattern D,D,D,D,I repeats; conflict_cnt_o increments every cycle.
- MaxInstrStall = 0, simultaneous requests -> instruction always wins; data is granted only when instr_req_i drops.
- MemLatency = 3, alternating grants I,D,I at t..t+2 -> rvalid I,D,I at t+3..t+5, with rdata routed to the matching port each cycle.
- rst_i asserted one cycle after a data read grant (MemLatency = 2) -> no data_rvalid_o after release; stall_cnt and conflict_cnt_o read 0.
